// File: rtl/mem_reader.sv
// rtl/mem_reader.sv - streaming read engine: issues memory reads, absorbs read latency, delivers words on a valid/ready stream.
// Optional feature: MEM_READER_STRIDE_EN adds the stride_i port (address increment sampled on start).
module mem_reader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 512,
  parameter int RD_LAT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [$clog2(DEPTH)-1:0]   base_addr_i,
  input  logic [$clog2(DEPTH+1)-1:0] count_i,
`ifdef MEM_READER_STRIDE_EN
  input  logic [$clog2(DEPTH)-1:0]   stride_i,
`endif
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       enB_o,
  output logic [$clog2(DEPTH)-1:0]   addrB_o,
  input  logic [WIDTH-1:0]           doutB_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [WIDTH-1:0]           m_data_o,
  output logic                       m_last_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int F  = RD_LAT + 2;
  localparam int PW = $clog2(F);
  localparam int OW = $clog2(F+1);
  localparam int IW = $clog2(RD_LAT+1);
  localparam int SW = OW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic [RD_LAT-1:0] pipe_q;
  logic [WIDTH-1:0]  fifo_q [F];
  logic [PW-1:0]     wr_q, rd_q;
  logic [OW-1:0]     occ_q;
  logic [AW-1:0]     inc;

  logic              issue, push, pop;
  logic [IW-1:0]     infl;
  logic [SW-1:0]     credit;
  logic [AW:0]       sum;
  logic [AW:0]       sum_wrap;

`ifdef MEM_READER_STRIDE_EN
  logic [AW-1:0] inc_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inc_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      inc_q <= stride_i;
    end
  end
  assign inc = inc_q;
`else
  assign inc = AW'(1);
`endif

  assign push = pipe_q[RD_LAT-1];
  assign pop  = m_valid_o && m_ready_i;

  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl = infl + IW'(pipe_q[i]);
    end
  end

  // Credit counts this cycle's pop so a full-rate stream never stalls issue.
  assign credit = SW'(occ_q) + SW'(infl) - SW'(pop);
  assign issue  = (state_q == RUN) && (rem_q != '0) && (credit < SW'(F));

  assign sum      = {1'b0, addr_q} + {1'b0, inc};
  assign sum_wrap = (sum >= (AW+1)'(DEPTH)) ? sum - (AW+1)'(DEPTH) : sum;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    beat_d  = pop ? beat_q + CW'(1) : beat_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          rem_d   = count_i;
          cnt_d   = count_i;
          beat_d  = '0;
          state_d = (count_i == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = sum_wrap[AW-1:0];
          rem_d  = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last_o) state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  // Issue flags travel alongside the memory's read latency; the tail flag marks doutB valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < F; i++) fifo_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= doutB_i;
        wr_q         <= (wr_q == PW'(F-1)) ? '0 : wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= (rd_q == PW'(F-1)) ? '0 : rd_q + PW'(1);
      end
      occ_q <= occ_q + OW'(push) - OW'(pop);
    end
  end

  assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
  assign done_o    = (state_q == FIN);
  assign enB_o     = issue;
  assign addrB_o   = addr_q;
  assign m_valid_o = (occ_q != '0);
  assign m_data_o  = fifo_q[rd_q];
  assign m_last_o  = m_valid_o && (beat_q == cnt_q - CW'(1));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) push |-> (occ_q != OW'(F)));

endmodule

// File: tb/tb_mem_reader.sv
// tb/tb_mem_reader.sv - randomized self-checking bench for mem_reader against an address-sequence reference model.
module tb_mem_reader;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 512;
  localparam int RD_LAT = 2;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH+1);
  localparam int F      = RD_LAT + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [CW-1:0]    count = '0;
`ifdef MEM_READER_STRIDE_EN
  logic [AW-1:0]    stride = '0;
`endif
  logic             busy, done, enB, m_valid, m_last;
  logic             m_ready = 1'b0;
  logic [AW-1:0]    addrB;
  logic [WIDTH-1:0] doutB, m_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] rd_pipe [RD_LAT];

  always #5 clk = ~clk;

  mem_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr), .count_i(count),
`ifdef MEM_READER_STRIDE_EN
    .stride_i(stride),
`endif
    .busy_o(busy), .done_o(done), .enB_o(enB), .addrB_o(addrB), .doutB_i(doutB),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last)
  );

  // Memory with RD_LAT register stages on the read path.
  always @(posedge clk) begin
    rd_pipe[0] <= enB ? mem[addrB] : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign doutB = rd_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {18'd0, busy, done, enB, addrB, m_valid, m_data, m_last}, 64'd0);
  endtask

  // mode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run_xfer(input int base, input int cnt, input int strd, input int mode, input bit intrude);
    int exp_q[$];
    int a, inc, nbeat, issued, maxout, first_k, done_k, budget;
    bit any_en, any_valid;
`ifdef MEM_READER_STRIDE_EN
    inc = strd;
`else
    inc = 1 + 0 * strd;
`endif
    a = base;
    for (int k = 0; k < cnt; k++) begin
      exp_q.push_back(a);
      a = (a + inc) % DEPTH;
    end
    nbeat = 0; issued = 0; maxout = 0; first_k = -1; done_k = -1;
    any_en = 0; any_valid = 0;
    budget = 4 * cnt + 40;
    @(negedge clk);
    start = 1'b1;
    base_addr = AW'(base);
    count = CW'(cnt);
`ifdef MEM_READER_STRIDE_EN
    stride = AW'(strd);
`endif
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (intrude && k == 2) begin
        start = 1'b1;
        base_addr = AW'(base + 77);
        count = CW'(3);
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 4 == 0) || (k % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (k == 0) chk($sformatf("busy_at_start b%0d c%0d", base, cnt), 64'(busy), 64'(cnt != 0));
      if (enB) begin issued++; any_en = 1; end
      if (m_valid) any_valid = 1;
      if (m_valid && m_ready) begin
        if (nbeat < cnt) begin
          chk($sformatf("data b%0d beat%0d", base, nbeat), 64'(m_data), 64'(exp_q[nbeat]));
          chk($sformatf("last b%0d beat%0d", base, nbeat), 64'(m_last), 64'(nbeat == cnt - 1));
        end
        if (nbeat == 0) first_k = k;
        nbeat++;
      end
      if (issued - nbeat > maxout) maxout = issued - nbeat;
      if (done) begin
        done_k = k;
        chk($sformatf("busy_at_done b%0d", base), 64'(busy), 64'd0);
        break;
      end
    end
    chk($sformatf("beats b%0d c%0d", base, cnt), 64'(nbeat), 64'(cnt));
    chk($sformatf("done_seen b%0d", base), 64'(done_k >= 0), 64'd1);
    chk($sformatf("outstanding b%0d", base), 64'(maxout <= F), 64'd1);
    if (cnt == 0) begin
      chk("cnt0_done_time", 64'(done_k), 64'd0);
      chk("cnt0_no_enB", 64'(any_en), 64'd0);
      chk("cnt0_no_valid", 64'(any_valid), 64'd0);
    end else if (mode == 0) begin
      chk($sformatf("first_beat_lat b%0d", base), 64'(first_k), 64'(RD_LAT + 1));
      chk($sformatf("done_time b%0d", base), 64'(done_k), 64'(cnt + RD_LAT + 1));
    end
    @(negedge clk);
    #1;
    chk($sformatf("done_pulse_end b%0d", base), 64'({done, busy, m_valid}), 64'd0);
  endtask

  initial begin
    int nb;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;

    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset_outputs");
    rst = 1'b0;

    run_xfer(10, 8, 1, 0, 0);
    run_xfer(508, 6, 1, 0, 0);
    run_xfer(10, 8, 1, 1, 0);
    run_xfer(20, 0, 1, 0, 0);
    run_xfer(10, 8, 1, 0, 1);
`ifdef MEM_READER_STRIDE_EN
    run_xfer(500, 4, 5, 0, 0);
    run_xfer(37, 5, 0, 2, 0);
`endif

    // Reset during the 4th beat of a count=8 transfer.
    @(negedge clk);
    start = 1'b1; base_addr = AW'(10); count = CW'(8);
`ifdef MEM_READER_STRIDE_EN
    stride = AW'(1);
`endif
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      m_ready = 1'b1;
      #1;
      if (m_valid && m_ready) begin
        nb++;
        if (nb == 4) begin
          chk("beat4_before_reset", 64'(m_data), 64'd13);
          rst = 1'b1;
          #1;
          chk_zero("async_reset_outputs");
          break;
        end
      end
    end
    chk("reached_beat4", 64'(nb), 64'd4);
    @(negedge clk);
    #1;
    chk_zero("reset_held_outputs");
    rst = 1'b0;
    run_xfer(0, 2, 1, 0, 0);

    run_xfer(100, DEPTH, 1, 2, 0);
    for (int t = 0; t < 12; t++) begin
      run_xfer(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 40)),
               int'($urandom_range(0, DEPTH-1)), t % 3, (t % 4 == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
